// File: rtl/simon_input_capture.sv
// simon_input_capture
// Player-side reader for the Simon colour sequence. The four raw colour
// buttons are synchronised and debounced, each clean single press becomes a
// 2-bit colour code, and the codes are packed into a 32-bit word laid out the
// same way display_state reads it from MEM (colour n at bits [2n+1:2n]).
// The block also reports round completion, inactivity timeout and presses
// where more than one button was held at once.

module simon_input_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_LEN         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [4:0]  round_len,
  input  logic [3:0]  buttons,
  output logic [31:0] seq_out,
  output logic [1:0]  colour,
  output logic        colour_valid,
  output logic [4:0]  press_count,
  output logic        complete,
  output logic        timed_out,
  output logic        multi_press
);

  localparam int STAB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [STAB_W-1:0]  STAB_MAX   = STAB_W'(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0]  STAB_ONE   = STAB_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [4:0]         LEN_MAX    = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_ARMED,
    S_DONE,
    S_TIMEOUT
  } state_t;

  // Synchroniser stages
  logic [3:0] b_meta_q, b_meta_d;
  logic [3:0] bsync_q,  bsync_d;

  // Debouncer: candidate pattern and how long it has been held
  logic [3:0]        cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;

  // Round control
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]        seq_q, seq_d;
  logic [1:0]         colour_q, colour_d;
  logic               colour_valid_q, colour_valid_d;
  logic [4:0]         press_count_q, press_count_d;
  logic               multi_q, multi_d;

  // Decoded view of the pattern that is (or is becoming) stable
  logic       pat_stable;
  logic       pat_zero;
  logic       pat_single;
  logic [1:0] pat_code;
  logic [4:0] len_clamped;
  logic [3:0] slot;

  // Two-flop synchroniser on the raw buttons; only bsync is used downstream
  always_comb begin
    b_meta_d = buttons;
    bsync_d  = b_meta_q;
  end

  // Track the current synchronised pattern and saturate its run length
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (bsync_q == cand_q) begin
      if (stab_q != STAB_MAX) begin
        stab_d = stab_q + STAB_ONE;
      end
    end else begin
      cand_d = bsync_q;
      stab_d = STAB_ONE;
    end
  end

  // Classify the candidate pattern; decisions are taken on the edge at which
  // the run length reaches its limit so the press is accepted on that edge
  always_comb begin
    pat_stable = (stab_d == STAB_MAX);
    pat_zero   = (cand_d == 4'b0000);
    pat_single = 1'b0;
    pat_code   = 2'd0;
    case (cand_d)
      4'b0001: begin pat_single = 1'b1; pat_code = 2'd0; end
      4'b0010: begin pat_single = 1'b1; pat_code = 2'd1; end
      4'b0100: begin pat_single = 1'b1; pat_code = 2'd2; end
      4'b1000: begin pat_single = 1'b1; pat_code = 2'd3; end
      default: begin pat_single = 1'b0; pat_code = 2'd0; end
    endcase
  end

  // Clamp the requested round length and pick the slot for the next colour
  always_comb begin
    len_clamped = (round_len > LEN_MAX) ? LEN_MAX : round_len;
    slot        = press_count_q[3:0];
  end

  // Round state machine: next state and all registered outputs
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    seq_d          = seq_q;
    colour_d       = colour_q;
    colour_valid_d = 1'b0;
    press_count_d  = press_count_q;
    multi_d        = multi_q;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          seq_d         = 32'd0;
          press_count_d = 5'd0;
          multi_d       = 1'b0;
          timer_d       = '0;
          state_d       = (len_clamped == 5'd0) ? S_DONE : S_RELEASE;
        end

        S_RELEASE: begin
          if (pat_stable && pat_zero) begin
            timer_d = '0;
            state_d = S_ARMED;
          end
        end

        S_ARMED: begin
          timer_d = timer_q + TIMER_ONE;
          if (pat_stable && pat_single) begin
            seq_d[{slot, 1'b0} +: 2] = pat_code;
            colour_d       = pat_code;
            colour_valid_d = 1'b1;
            press_count_d  = press_count_q + 5'd1;
            timer_d        = '0;
            state_d        = (press_count_q + 5'd1 == len_clamped) ? S_DONE : S_RELEASE;
          end else if (pat_stable && !pat_zero) begin
            multi_d = 1'b1;
            timer_d = '0;
            state_d = S_RELEASE;
          end else if (timer_q == TIMER_LAST) begin
            timer_d = timer_q;
            state_d = S_TIMEOUT;
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        S_TIMEOUT: begin
          state_d = S_TIMEOUT;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_meta_q       <= 4'b0000;
      bsync_q        <= 4'b0000;
      cand_q         <= 4'b0000;
      stab_q         <= '0;
      state_q        <= S_IDLE;
      timer_q        <= '0;
      seq_q          <= 32'd0;
      colour_q       <= 2'd0;
      colour_valid_q <= 1'b0;
      press_count_q  <= 5'd0;
      multi_q        <= 1'b0;
    end else begin
      b_meta_q       <= b_meta_d;
      bsync_q        <= bsync_d;
      cand_q         <= cand_d;
      stab_q         <= stab_d;
      state_q        <= state_d;
      timer_q        <= timer_d;
      seq_q          <= seq_d;
      colour_q       <= colour_d;
      colour_valid_q <= colour_valid_d;
      press_count_q  <= press_count_d;
      multi_q        <= multi_d;
    end
  end

  // Drive the ports straight from registers and decoded state
  always_comb begin
    seq_out      = seq_q;
    colour       = colour_q;
    colour_valid = colour_valid_q;
    press_count  = press_count_q;
    multi_press  = multi_q;
    complete     = (state_q == S_DONE);
    timed_out    = (state_q == S_TIMEOUT);
  end

endmodule

// File: tb/tb_simon_input_capture.sv
// Testbench for simon_input_capture.
// Stimulus tasks predict each accepted press from the game rules and queue it;
// a negedge monitor pops the queue whenever colour_valid is seen.

module tb_simon_input_capture;

  localparam int DEB       = 4;
  localparam int TMO       = 64;
  localparam int PULSE_LAT = DEB + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [4:0]  round_len = 5'd0;
  logic [3:0]  buttons = 4'b0000;
  logic [31:0] seq_out;
  logic [1:0]  colour;
  logic        colour_valid;
  logic [4:0]  press_count;
  logic        complete;
  logic        timed_out;
  logic        multi_press;

  simon_input_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .MAX_LEN        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .round_len   (round_len),
    .buttons     (buttons),
    .seq_out     (seq_out),
    .colour      (colour),
    .colour_valid(colour_valid),
    .press_count (press_count),
    .complete    (complete),
    .timed_out   (timed_out),
    .multi_press (multi_press)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to timestamp presses and pulses
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] col;
    int         slot;
    int         cycle;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model of the round in progress
  int          m_count;
  int          m_len;
  logic [31:0] m_seq;
  logic        m_multi;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a round; the rules allow one cycle in IDLE and one to confirm release
  task automatic startRound(input int len);
    round_len = 5'(len);
    m_len     = (len > 16) ? 16 : len;
    m_count   = 0;
    m_seq     = 32'd0;
    m_multi   = 1'b0;
    en        = 1'b1;
    tick(3);
  endtask

  // Optional bounce, a hold of 'hold' cycles, then 'gap' released cycles
  task automatic applyStimulus(input logic [3:0] pat, input int bounce, input int hold, input int gap);
    int         start;
    logic [1:0] col;
    bit         single;
    for (int i = 0; i < bounce; i++) begin
      buttons = (i % 2 == 0) ? pat : 4'b0000;
      tick(1);
    end
    start  = cyc;
    single = 1'b0;
    col    = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (pat == 4'(1 << b)) begin
        single = 1'b1;
        col    = 2'(b);
      end
    end
    if (hold >= DEB && en && m_count < m_len) begin
      if (single) begin
        exp_q.push_back('{col, m_count, start + PULSE_LAT});
        m_seq[2*m_count +: 2] = col;
        m_count++;
      end else if (pat != 4'b0000) begin
        m_multi = 1'b1;
      end
    end
    buttons = pat;
    tick(hold);
    buttons = 4'b0000;
    tick(gap);
  endtask

  // Compare round-level outputs with the model, then close the round
  task automatic endRound(input string tag);
    checkOutput({tag, " complete"}, 32'(complete), 32'(m_count == m_len));
    checkOutput({tag, " press_count"}, 32'(press_count), 32'(m_count));
    checkOutput({tag, " seq_out"}, seq_out, m_seq);
    checkOutput({tag, " multi_press"}, 32'(multi_press), 32'(m_multi));
    checkOutput({tag, " timed_out"}, 32'(timed_out), 32'd0);
    en = 1'b0;
    tick(2);
    checkOutput({tag, " complete after en low"}, 32'(complete), 32'd0);
    checkOutput({tag, " seq_out retained"}, seq_out, m_seq);
    checkOutput({tag, " press_count retained"}, 32'(press_count), 32'(m_count));
  endtask

  task automatic randomRound(input int len, input int presses, input string tag);
    bit glitched;
    glitched = 1'b0;
    startRound(len);
    for (int p = 0; p < presses; p++) begin
      int         r;
      logic [3:0] pat;
      logic [3:0] multi_pats [8];
      multi_pats = '{4'b0011, 4'b0101, 4'b1001, 4'b0110, 4'b1010, 4'b1100, 4'b0111, 4'b1111};
      r   = int'($urandom_range(0, 9));
      pat = 4'(1 << $urandom_range(0, 3));
      if (r == 0 && !glitched) begin
        applyStimulus(pat, 0, DEB - 1, int'($urandom_range(DEB + 2, 12)));
        glitched = 1'b1;
      end else if (r == 1) begin
        applyStimulus(multi_pats[$urandom_range(0, 7)], 0, int'($urandom_range(DEB, 10)),
                      int'($urandom_range(DEB + 2, 12)));
        glitched = 1'b0;
      end else begin
        applyStimulus(pat, 2 * int'($urandom_range(0, 2)), int'($urandom_range(DEB, 12)),
                      int'($urandom_range(DEB + 2, 12)));
        glitched = 1'b0;
      end
    end
    endRound(tag);
  endtask

  // Monitor: every colour_valid pulse must match the oldest predicted press
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && colour_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected colour_valid", 32'(colour_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pulse colour", 32'(colour), 32'(e.col));
        checkOutput("pulse cycle", 32'(cyc), 32'(e.cycle));
        checkOutput("pulse press_count", 32'(press_count), 32'(e.slot + 1));
        checkOutput("pulse seq slot", 32'(seq_out[2*e.slot +: 2]), 32'(e.col));
      end
    end
  end

  // Absolute bound on simulation time
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;

    // Reset state
    tick(3);
    checkOutput("reset seq_out", seq_out, 32'd0);
    checkOutput("reset outputs",
                32'({colour, colour_valid, press_count, complete, timed_out, multi_press}), 32'd0);
    rst_n = 1'b1;
    tick(6);

    // Three clean presses: colours 1, 3, 0
    startRound(3);
    applyStimulus(4'b0010, 0, 10, 10);
    applyStimulus(4'b1000, 0, 10, 10);
    applyStimulus(4'b0001, 0, 10, 10);
    checkOutput("T1 seq_out", seq_out, 32'h0000_000D);
    endRound("T1");

    // Bouncing press followed by a steady hold
    startRound(1);
    applyStimulus(4'b0100, 4, 10, 10);
    endRound("T2");

    // Two buttons together, then a clean press
    startRound(1);
    applyStimulus(4'b0011, 0, 10, 10);
    checkOutput("T3 multi_press", 32'(multi_press), 32'd1);
    checkOutput("T3 no capture", 32'(press_count), 32'd0);
    applyStimulus(4'b0100, 0, 10, 10);
    checkOutput("T3 seq low", 32'(seq_out[1:0]), 32'd2);
    endRound("T3");

    // Exact-threshold hold accepted, one-short hold rejected
    startRound(2);
    applyStimulus(4'b1000, 0, DEB - 1, 10);
    applyStimulus(4'b0010, 0, DEB, 10);
    applyStimulus(4'b0001, 0, DEB, 10);
    endRound("T3b");

    // No press: timeout 64 cycles after ARMED is entered
    tick(4);
    round_len = 5'd2;
    en = 1'b1;
    c = cyc;
    tick(2 + TMO - 1);
    checkOutput("T4 timed_out early", 32'(timed_out), 32'd0);
    tick(1);
    checkOutput("T4 timed_out", 32'(timed_out), 32'd1);
    checkOutput("T4 complete", 32'(complete), 32'd0);
    checkOutput("T4 seq_out", seq_out, 32'd0);
    checkOutput("T4 cycles", 32'(cyc - c), 32'(2 + TMO));
    en = 1'b0;
    tick(2);
    checkOutput("T4 timed_out cleared", 32'(timed_out), 32'd0);

    // Button already held when the round starts
    buttons = 4'b0001;
    tick(8);
    startRound(1);
    tick(20);
    checkOutput("T5 held not accepted", 32'(press_count), 32'd0);
    buttons = 4'b0000;
    tick(8);
    applyStimulus(4'b0001, 0, 8, 10);
    endRound("T5");

    // Asynchronous reset in the middle of a round
    startRound(4);
    applyStimulus(4'b0100, 0, 8, 10);
    applyStimulus(4'b0010, 0, 8, 10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("T6 async seq_out", seq_out, 32'd0);
    checkOutput("T6 async outputs",
                32'({colour, colour_valid, press_count, complete, timed_out, multi_press}), 32'd0);
    tick(2);
    rst_n   = 1'b1;
    m_count = 0;
    m_seq   = 32'd0;
    m_multi = 1'b0;
    tick(8);
    checkOutput("T6 new round seq_out", seq_out, 32'd0);
    applyStimulus(4'b1000, 0, 8, 10);
    endRound("T6");

    // Randomised rounds, including clamped and empty lengths
    randomRound(int'($urandom_range(1, 16)), 18, "R1");
    randomRound(int'($urandom_range(1, 16)), 18, "R2");
    randomRound(20, 18, "R3");
    randomRound(0, 2, "R4");

    tick(10);
    checkOutput("pending pulses", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
